// File: rtl/pixel_serializer.sv
// Upstream feeder for the single-bit NeoPixel writer: serializes 24-bit GRB pixels MSB first,
// paced by the writer's busy flag, then idles the line for a latch interval after each frame.
module pixel_serializer #(
  parameter int clk_in_rate_hz = 12_000_000,
  parameter int PIXEL_COUNT    = 8,
  parameter int LATCH_CYCLES   = 720
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        bit_value,
  output logic        bit_valid,
  input  logic        bit_busy,
  output logic        frame_done
);
  localparam int              LW         = $clog2(LATCH_CYCLES + 1);
  localparam logic [7:0]      LAST_PIX   = 8'(PIXEL_COUNT - 1);
  localparam logic [LW-1:0]   LATCH_LOAD = LW'(LATCH_CYCLES);
  localparam logic [LW-1:0]   LATCH_ONE  = LW'(1);

  if (clk_in_rate_hz < 1 || PIXEL_COUNT < 1 || PIXEL_COUNT > 255 || LATCH_CYCLES < 1) begin : g_param_check
    $error("pixel_serializer: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_LATCH     = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [23:0]   shift_q, shift_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    pix_idx_q, pix_idx_d;
  logic [LW-1:0] latch_q, latch_d;
  logic          pixel_ready_q, pixel_ready_d;
  logic          bit_valid_q, bit_valid_d;
  logic          bit_value_q, bit_value_d;
  logic          frame_done_q, frame_done_d;

  // Next-state logic; outputs are decoded from the next state so they can be registered.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    pix_idx_d   = pix_idx_q;
    latch_d     = latch_q;
    case (state_q)
      S_IDLE: begin
        if (pixel_valid && pixel_ready_q) begin
          shift_d   = pixel_data;
          bit_cnt_d = 5'd0;
          state_d   = S_SEND;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_SEND: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (bit_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_DONE: begin
        if (!bit_busy) begin
          if (bit_cnt_q < 5'd23) begin
            shift_d   = {shift_q[22:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 5'd1;
            state_d   = S_SEND;
          end else if (pix_idx_q < LAST_PIX) begin
            pix_idx_d = pix_idx_q + 8'd1;
            state_d   = S_IDLE;
          end else begin
            pix_idx_d = 8'd0;
            latch_d   = LATCH_LOAD;
            state_d   = S_LATCH;
          end
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_LATCH: begin
        latch_d = latch_q - LATCH_ONE;
        // latch_q counts the latch clocks still to run, including the current one
        if (latch_q <= LATCH_ONE) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_LATCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    pixel_ready_d = (state_d == S_IDLE);
    bit_valid_d   = (state_d == S_SEND);
    bit_value_d   = (state_d == S_SEND) ? shift_d[23] : bit_value_q;
    frame_done_d  = (state_d == S_LATCH) && (latch_d == LATCH_ONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      shift_q       <= 24'd0;
      bit_cnt_q     <= 5'd0;
      pix_idx_q     <= 8'd0;
      latch_q       <= '0;
      pixel_ready_q <= 1'b0;
      bit_valid_q   <= 1'b0;
      bit_value_q   <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      pix_idx_q     <= pix_idx_d;
      latch_q       <= latch_d;
      pixel_ready_q <= pixel_ready_d;
      bit_valid_q   <= bit_valid_d;
      bit_value_q   <= bit_value_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign pixel_ready = pixel_ready_q;
  assign bit_valid   = bit_valid_q;
  assign bit_value   = bit_value_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_pixel_serializer.sv
// Directed bench for pixel_serializer with a busy-pacing writer model (busy 3 clocks after
// valid, held 5 clocks), PIXEL_COUNT=2, LATCH_CYCLES=10.
module tb_pixel_serializer;
  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        bit_value;
  logic        bit_valid;
  logic        bit_busy;
  logic        frame_done;

  pixel_serializer #(
    .clk_in_rate_hz(12_000_000),
    .PIXEL_COUNT   (2),
    .LATCH_CYCLES  (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_data (pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .bit_value  (bit_value),
    .bit_valid  (bit_valid),
    .bit_busy   (bit_busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          cyc = 0;
  int          n_strobe = 0, n_fd = 0, n_acc = 0, n_overlap = 0;
  logic [95:0] bits_v = '0;
  int          busy_fall_cyc = 0, ready_rise_cyc = 0, fd_cyc = 0;
  int          last_strobe_cyc = 0, gap_after_fd = 0, lat_len = 0;
  int          fd_strobe_last = 0, fd_strobe_prev = 0;
  logic        prev_ready = 1'b0;
  int          busy_delay = 3;
  int          wr_cnt = 0, wr_hold = 0;

  int          b_s, b_fd, b_acc, acc, n;
  logic        loop_done;
  logic [23:0] words [2];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor plus writer model, both sampled 1 time unit after the rising edge.
  initial begin
    bit_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (prev_ready === 1'b1 && pixel_valid === 1'b1 && reset === 1'b0) n_acc++;
      if (pixel_ready === 1'b1 && prev_ready !== 1'b1) ready_rise_cyc = cyc;
      prev_ready = pixel_ready;
      if (bit_valid === 1'b1) begin
        if (fd_cyc > last_strobe_cyc) gap_after_fd = cyc - last_strobe_cyc;
        n_strobe++;
        bits_v = {bits_v[94:0], bit_value};
        last_strobe_cyc = cyc;
      end
      if (frame_done === 1'b1) begin
        n_fd++;
        fd_cyc = cyc;
        lat_len = cyc - busy_fall_cyc;
        fd_strobe_prev = fd_strobe_last;
        fd_strobe_last = n_strobe;
        if (pixel_ready === 1'b1) n_overlap++;
      end
      if (reset === 1'b1) begin
        bit_busy = 1'b0;
        wr_cnt   = 0;
        wr_hold  = 0;
      end else if (wr_hold > 0) begin
        wr_hold--;
        if (wr_hold == 0) begin
          bit_busy = 1'b0;
          busy_fall_cyc = cyc;
        end
      end else if (wr_cnt > 0) begin
        wr_cnt--;
        if (wr_cnt == 0) begin
          bit_busy = 1'b1;
          wr_hold  = 5;
        end
      end else if (bit_valid === 1'b1) begin
        wr_cnt = busy_delay;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pixel_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_pixel(input logic [23:0] d);
    int k;
    k = 0;
    @(negedge clk);
    pixel_data  = d;
    pixel_valid = 1'b1;
    while (pixel_ready !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_eq("push_ready", 64'(pixel_ready === 1'b1), 64'd1);
    @(negedge clk);
    pixel_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (pixel_ready !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 64'(pixel_ready === 1'b1), 64'd1);
  endtask

  task automatic wait_fd(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (n_fd < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 64'(n_fd >= target), 64'd1);
  endtask

  initial begin
    reset       = 1'b1;
    pixel_valid = 1'b0;
    pixel_data  = 24'd0;

    // Reset state and ready rise
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", 64'({pixel_ready, bit_valid, bit_value, frame_done}), 64'd0);
    reset = 1'b0;
    check_eq("ready_in_rst", 64'(pixel_ready), 64'd0);
    @(negedge clk);
    check_eq("ready_after_rst", 64'(pixel_ready), 64'd1);

    // Single pixel 0xA50F81
    b_s = n_strobe;
    push_pixel(24'hA50F81);
    check_eq("t1_ready_low", 64'(pixel_ready), 64'd0);
    check_eq("t1_first_strobe", 64'({bit_valid, bit_value}), 64'd3);
    wait_ready("t1_ready_back", 1000);
    check_eq("t1_strobes", 64'(n_strobe - b_s), 64'd24);
    check_eq("t1_bits", 64'(bits_v[23:0]), 64'hA50F81);
    check_eq("t1_ready_rise", 64'(ready_rise_cyc - busy_fall_cyc), 64'd1);
    check_eq("t1_value_hold", 64'(bit_value), 64'd1);

    // Full frame 0xFFFFFF, 0x000000 and latch interval
    do_reset();
    b_s = n_strobe; b_fd = n_fd;
    push_pixel(24'hFFFFFF);
    push_pixel(24'h000000);
    wait_fd("t2_fd_seen", b_fd + 1, 2000);
    @(negedge clk);
    check_eq("t2_strobes", 64'(n_strobe - b_s), 64'd48);
    check_eq("t2_bits", 64'(bits_v[47:0]), 64'hFFFFFF000000);
    check_eq("t2_latch_len", 64'(lat_len), 64'd10);
    check_eq("t2_ready_after_fd", 64'(ready_rise_cyc - fd_cyc), 64'd1);
    check_eq("t2_ready_now", 64'({pixel_ready, frame_done}), 64'd2);
    check_eq("t2_fd_count", 64'(n_fd - b_fd), 64'd1);

    // pixel_valid held high with changing data; only words seen while ready get sent
    do_reset();
    b_s = n_strobe; b_fd = n_fd; b_acc = n_acc;
    words[0] = 24'h123456;
    words[1] = 24'hC3A5F0;
    acc = 0; n = 0; loop_done = 1'b0;
    @(negedge clk);
    while (!loop_done && n < 3000) begin
      if (pixel_ready === 1'b1) begin
        if (acc < 2) begin
          pixel_data  = words[acc];
          pixel_valid = 1'b1;
          acc++;
        end else begin
          pixel_valid = 1'b0;
          loop_done   = 1'b1;
        end
      end else begin
        pixel_data  = 24'($urandom);
        pixel_valid = 1'b1;
      end
      if (!loop_done) begin
        @(negedge clk);
        n++;
      end
    end
    pixel_valid = 1'b0;
    check_eq("t3_accepts", 64'(n_acc - b_acc), 64'd2);
    check_eq("t3_strobes", 64'(n_strobe - b_s), 64'd48);
    check_eq("t3_bits", 64'(bits_v[47:0]), 64'h123456C3A5F0);
    check_eq("t3_fd_count", 64'(n_fd - b_fd), 64'd1);

    // Reset after 7 bits of pixel 0 aborts the frame
    do_reset();
    b_s = n_strobe; b_fd = n_fd;
    push_pixel(24'hFFFFFF);
    n = 0;
    while (n_strobe - b_s < 7 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("t4_seven_bits", 64'(n_strobe - b_s), 64'd7);
    do_reset();
    repeat (60) @(negedge clk);
    check_eq("t4_no_strobe", 64'(n_strobe - b_s), 64'd7);
    check_eq("t4_no_fd", 64'(n_fd - b_fd), 64'd0);
    push_pixel(24'h0F0F0F);
    wait_ready("t4_px0_done", 1000);
    check_eq("t4_no_fd_one_px", 64'(n_fd - b_fd), 64'd0);
    push_pixel(24'hF0F0F0);
    wait_fd("t4_fd_seen", b_fd + 1, 1000);
    check_eq("t4_strobes", 64'(n_strobe - b_s), 64'd55);
    check_eq("t4_bits", 64'(bits_v[47:0]), 64'h0F0F0FF0F0F0);

    // Writer delays busy by 40 clocks
    do_reset();
    b_s = n_strobe;
    busy_delay = 40;
    push_pixel(24'h800001);
    repeat (30) @(negedge clk);
    check_eq("t5_stalled", 64'(n_strobe - b_s), 64'd1);
    busy_delay = 3;
    wait_ready("t5_ready_back", 1000);
    check_eq("t5_strobes", 64'(n_strobe - b_s), 64'd24);
    check_eq("t5_bits", 64'(bits_v[23:0]), 64'h800001);

    // Back-to-back frames with pixel_valid constant high
    do_reset();
    b_s = n_strobe; b_fd = n_fd;
    @(negedge clk);
    pixel_data  = 24'h5A5A5A;
    pixel_valid = 1'b1;
    n = 0;
    while (n_fd - b_fd < 2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    pixel_valid = 1'b0;
    check_eq("t6_fd_count", 64'(n_fd - b_fd), 64'd2);
    check_eq("t6_bits_per_frame", 64'(fd_strobe_last - fd_strobe_prev), 64'd48);
    check_eq("t6_latch_len", 64'(lat_len), 64'd10);
    // 8 busy clocks + 1 + 10 latch clocks + 1 ready clock between strobes
    check_eq("t6_strobe_gap", 64'(gap_after_fd), 64'd20);
    @(negedge clk);
    check_eq("t6_ready_after_fd", 64'(ready_rise_cyc - fd_cyc), 64'd1);
    check_eq("t6_bits", 64'(bits_v[47:0]), 64'h5A5A5A5A5A5A);
    repeat (5) @(negedge clk);
    check_eq("t6_no_extra", 64'(n_strobe - b_s), 64'd96);

    check_eq("fd_ready_overlap", 64'(n_overlap), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
